// File: rtl/enemy_spawn_scheduler_if.sv
// -----------------------------------------------------------------------------
// enemy_spawn_scheduler_if
// Spawn request bundle between the spawn scheduler and the enemy slot array.
//
//   Spawn_Req   scheduler -> array   a spawn is requested
//   Spawn_Slot  scheduler -> array   slot to fill, valid while Spawn_Req
//   Spawn_X/Y   scheduler -> array   spawn position, valid while Spawn_Req
//   Spawn_Ack   array -> scheduler   request accepted (looked at only while Spawn_Req)
//
// master: the scheduler side.  slave: the enemy array side.
// -----------------------------------------------------------------------------
interface enemy_spawn_scheduler_if #(
    parameter int SLOT_W = 3
);
    logic              Spawn_Req;
    logic [SLOT_W-1:0] Spawn_Slot;
    logic [8:0]        Spawn_X;
    logic [8:0]        Spawn_Y;
    logic              Spawn_Ack;

    modport master (
        output Spawn_Req,
        output Spawn_Slot,
        output Spawn_X,
        output Spawn_Y,
        input  Spawn_Ack
    );

    modport slave (
        input  Spawn_Req,
        input  Spawn_Slot,
        input  Spawn_X,
        input  Spawn_Y,
        output Spawn_Ack
    );
endinterface

// File: rtl/enemy_spawn_scheduler.sv
// -----------------------------------------------------------------------------
// enemy_spawn_scheduler
// Paces enemy respawns from the level's unit time (frame ticks between spawns),
// looks for a free enemy slot round-robin, picks one of four spawn points and
// issues a single spawn request at a time to the enemy array.
//
// Ports
//   Clk          system clock
//   Reset_n      asynchronous reset, active low
//   Frame_Tick   one-Clk pulse per video frame
//   Pause        freezes the timer and the slot search; a pending request stays up
//   Unit_Time    frames between spawns (0 behaves as 1), may change at any time
//   Enemy_Alive  bit i set when enemy slot i is occupied
//   Spawn_Count  accepted spawns, saturating at 1023
//   spawn        request bundle (master side): Spawn_Req/Slot/X/Y out, Spawn_Ack in
//
// Build option
//   SPAWN_LFSR_EN  when defined, the spawn point index is the low two bits of a
//                  free-running 8-bit Fibonacci LFSR (taps 8,6,5,4, seed 8'hA5)
//                  sampled when a request is formed; otherwise the point index
//                  steps 0,1,2,3,0... on each accepted spawn.
// -----------------------------------------------------------------------------
module enemy_spawn_scheduler #(
    parameter int          NUM_ENEMY = 8,
    parameter int          SLOT_W    = 3,
    parameter logic [35:0] SPAWN_XS  = {9'd296, 9'd8, 9'd296, 9'd8},
    parameter logic [35:0] SPAWN_YS  = {9'd216, 9'd216, 9'd8, 9'd8}
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 Frame_Tick,
    input  logic                 Pause,
    input  logic [9:0]           Unit_Time,
    input  logic [NUM_ENEMY-1:0] Enemy_Alive,
    output logic [9:0]           Spawn_Count,
    enemy_spawn_scheduler_if.master spawn
);

    typedef enum logic [1:0] {
        COUNT  = 2'd0,
        SEARCH = 2'd1,
        REQ    = 2'd2
    } state_t;

    localparam logic [9:0]        TIMER_MAX = 10'd1023;
    localparam logic [9:0]        COUNT_MAX = 10'd1023;
    localparam logic [SLOT_W-1:0] LAST_OFS  = SLOT_W'(NUM_ENEMY - 1);

    state_t            state;
    state_t            state_next;

    logic [9:0]        timer;
    logic              retry_hold;   // search came up empty; wait for a frame tick
    logic [SLOT_W-1:0] rr_ptr;
    logic [SLOT_W-1:0] search_idx;
    logic [SLOT_W-1:0] search_ofs;   // slots already examined in this search
    logic [1:0]        point_idx;

    logic [9:0]        unit_eff;
    logic              tick_en;
    logic              expired;
    logic              start_search;
    logic              search_step;
    logic              slot_free;
    logic              found;
    logic              exhausted;
    logic              accept;

    function automatic logic [8:0] point_x(input logic [1:0] idx);
        return SPAWN_XS[int'(idx)*9 +: 9];
    endfunction

    function automatic logic [8:0] point_y(input logic [1:0] idx);
        return SPAWN_YS[int'(idx)*9 +: 9];
    endfunction

    // ------------------------------------------------------------------
    // Decode of the current cycle's events
    // ------------------------------------------------------------------
    always_comb begin
        unit_eff     = (Unit_Time == 10'd0) ? 10'd1 : Unit_Time;
        tick_en      = Frame_Tick & ~Pause;
        expired      = (timer >= unit_eff);
        // After an all-busy search the timer stays expired; only the next
        // frame tick may launch another search, otherwise the FSM would
        // spin through SEARCH continuously.
        start_search = (state == COUNT) && !Pause && expired &&
                       (!retry_hold || tick_en);
        search_step  = (state == SEARCH) && !Pause;
        slot_free    = ~Enemy_Alive[search_idx];
        found        = search_step && slot_free;
        exhausted    = search_step && !slot_free && (search_ofs == LAST_OFS);
        accept       = (state == REQ) && spawn.Spawn_Ack;
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= COUNT;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            COUNT: begin
                if (start_search) begin
                    state_next = SEARCH;
                end
            end
            SEARCH: begin
                if (found) begin
                    state_next = REQ;
                end else if (exhausted) begin
                    state_next = COUNT;
                end
            end
            REQ: begin
                if (accept) begin
                    state_next = COUNT;
                end
            end
            default: state_next = COUNT;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        spawn.Spawn_Req = (state == REQ);
    end

    // ------------------------------------------------------------------
    // Frame timer and retry hold
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            timer      <= 10'd0;
            retry_hold <= 1'b0;
        end else begin
            // An ack in the same cycle as a frame tick restarts at 0.
            if (accept) begin
                timer <= 10'd0;
            end else if ((state == COUNT) && !start_search && tick_en &&
                         (timer != TIMER_MAX)) begin
                timer <= timer + 10'd1;
            end

            if (accept || start_search) begin
                retry_hold <= 1'b0;
            end else if (exhausted) begin
                retry_hold <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Round-robin slot search
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rr_ptr     <= '0;
            search_idx <= '0;
            search_ofs <= '0;
        end else begin
            if (accept) begin
                rr_ptr <= spawn.Spawn_Slot + 1'b1;   // wraps by truncation
            end

            if (start_search) begin
                search_idx <= rr_ptr;
                search_ofs <= '0;
            end else if (search_step && !slot_free) begin
                search_idx <= search_idx + 1'b1;
                search_ofs <= search_ofs + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Spawn point selection
    // ------------------------------------------------------------------
`ifdef SPAWN_LFSR_EN
    logic [7:0] lfsr;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            lfsr <= 8'hA5;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    always_comb begin
        point_idx = lfsr[1:0];
    end
`else
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            point_idx <= 2'd0;
        end else if (accept) begin
            point_idx <= point_idx + 2'd1;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Request payload, held stable from SEARCH->REQ until the ack
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            spawn.Spawn_Slot <= '0;
            spawn.Spawn_X    <= point_x(2'd0);
            spawn.Spawn_Y    <= point_y(2'd0);
        end else if (found) begin
            spawn.Spawn_Slot <= search_idx;
            spawn.Spawn_X    <= point_x(point_idx);
            spawn.Spawn_Y    <= point_y(point_idx);
        end
    end

    // ------------------------------------------------------------------
    // Accepted spawn counter
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Spawn_Count <= 10'd0;
        end else if (accept && (Spawn_Count != COUNT_MAX)) begin
            Spawn_Count <= Spawn_Count + 10'd1;
        end
    end

endmodule
